// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receive frame sequencer.
package uart_rx_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PRESC_W    = 6;
  localparam int EDGE_W     = 5;
  localparam int BIT_W      = 4;

  localparam logic [PRESC_W-1:0] PRESC_8  = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] PRESC_16 = PRESC_W'(16);
  localparam logic [PRESC_W-1:0] PRESC_32 = PRESC_W'(32);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CHECK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter, data-bit counter and latched prescale for the RX sequencer.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int PW = PRESC_W,
  parameter int EW = EDGE_W,
  parameter int BW = BIT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_cnt_en,
  input  logic          i_cnt_clr,
  input  logic          i_bit_inc,
  input  logic [PW-1:0] i_presc,
  output logic [EW-1:0] o_edge_count,
  output logic [BW-1:0] o_bit_count,
  output logic          o_bit_end,
  output logic          o_last_bit
);

  logic [PW-1:0] r_presc;
  logic [EW-1:0] r_edge;
  logic [BW-1:0] r_bit;
  logic [PW-1:0] w_presc_m1;

  // Compares use the latched value so Prescale may change freely mid-frame.
  assign w_presc_m1   = r_presc - PW'(1);
  assign o_bit_end    = (PW'(r_edge) == w_presc_m1);
  assign o_last_bit   = (r_bit == BW'(DW - 1));
  assign o_edge_count = r_edge;
  assign o_bit_count  = r_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_presc <= '0;
    else if (i_load) r_presc <= i_presc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_edge <= '0;
    else if (i_cnt_clr) r_edge <= '0;
    else if (i_cnt_en)  r_edge <= o_bit_end ? '0 : r_edge + EW'(1);
  end

  // Wraps after the last data bit so the visible index never leaves 0..DW-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_bit <= '0;
    else if (i_load)                 r_bit <= '0;
    else if (i_bit_inc && o_bit_end) r_bit <= o_last_bit ? '0 : r_bit + BW'(1);
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start detect, bit timing and checker/deserializer enables.
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [EDGE_W-1:0]  edge_count,
  output logic [BIT_W-1:0]   bit_count,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid
);

  rx_state_e r_state, w_next;
  logic      r_perr;
  logic      w_bit_end, w_last_bit;
  logic      w_load, w_cnt_en, w_cnt_clr, w_bit_inc;

  uart_rx_edge_bit_counter u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_cnt_en     (w_cnt_en),
    .i_cnt_clr    (w_cnt_clr),
    .i_bit_inc    (w_bit_inc),
    .i_presc      (Prescale),
    .o_edge_count (edge_count),
    .o_bit_count  (bit_count),
    .o_bit_end    (w_bit_end),
    .o_last_bit   (w_last_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!RX_IN) w_next = START;
      START:   if (w_bit_end) w_next = strt_glitch ? IDLE : DATA;
      DATA:    if (w_bit_end && w_last_bit) w_next = PAR_EN ? PARITY : STOP;
      PARITY:  if (w_bit_end) w_next = STOP;
      STOP:    if (w_bit_end) w_next = CHECK;
      CHECK:   w_next = RX_IN ? IDLE : START;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    dat_samp_en = (r_state != IDLE);
    strt_chk_en = (r_state == START);
    deser_en    = (r_state == DATA);
    par_chk_en  = (r_state == PARITY);
    stp_chk_en  = (r_state == STOP);
    // Entering START from CHECK keeps counting, so a back-to-back frame begins at edge 1.
    w_load      = (w_next == START) && (r_state != START);
    w_cnt_en    = (r_state != IDLE);
    w_cnt_clr   = (w_next == IDLE);
    w_bit_inc   = (r_state == DATA);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perr     <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= (r_state == CHECK) && !(r_perr | stp_err);
      if (w_load)                              r_perr <= 1'b0;
      else if ((r_state == PARITY) && w_bit_end) r_perr <= par_err;
    end
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Frame-sequencing controller for the UART receiver. It detects the start bit on RX_IN and runs the oversampling edge counter and the bit counter. It drives the enables for the data sampler, the deserializer and the start/parity/stop checkers, and emits a one-cycle data_valid when a frame is error-free. It sits between the RX pin and the deserializer, parity_check, strt_check and stp_check blocks.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESC_W, 6, Prescale width
EDGE_W, 5, edge_count width (supports Prescale up to 32)

Ports:
clk  in  1  receiver oversampling clock
rst  in  1  asynchronous active-low reset
RX_IN  in  1  serial line (idle high)
PAR_EN  in  1  1 = frame carries a parity bit
Prescale  in  PRESC_W  oversampling ratio; legal values 8, 16, 32
strt_glitch  in  1  start checker: sampled start bit was 1
par_err  in  1  parity checker error flag
stp_err  in  1  stop checker error flag
edge_count  out  EDGE_W  position within current bit, 0..Prescale-1
bit_count  out  4  data bit index, 0..DATA_WIDTH-1
dat_samp_en  out  1  data sampler enable
deser_en  out  1  deserializer shift enable
strt_chk_en  out  1  start checker enable
par_chk_en  out  1  parity checker enable
stp_chk_en  out  1  stop checker enable
data_valid  out  1  one-cycle pulse: P_DATA holds a good frame

Behaviour:
- Reset (async, rst=0): state=IDLE; edge_count=0, bit_count=0; all enables 0; data_valid=0; latched prescale=0.
- Prescale handling:
  - Prescale is latched into presc_q on the IDLE->START transition. All compares use presc_q, so mid-frame changes on Prescale are ignored.
  - bit_end = (edge_count == presc_q-1).
  - Illegal Prescale values are not checked; counters still wrap at presc_q-1.
- Edge counter:
  - Increments every cycle outside IDLE.
  - Wraps to 0 on bit_end.
  - Held at 0 in IDLE.
- Bit counter:
  - Increments on bit_end in DATA only.
  - Cleared on entry to START.
- States and transitions:
  - IDLE: when RX_IN==0, go to START with edge_count=0.
  - START:
    - strt_chk_en=1.
    - On bit_end, strt_glitch=1 goes to IDLE (abort, no data_valid). Otherwise go to DATA.
  - DATA:
    - deser_en=1.
    - On bit_end with bit_count==DATA_WIDTH-1, go to PARITY if PAR_EN else STOP.
    - The deserializer shifts at edge_count==presc_q/2+2; deser_en stays high for the whole bit time.
  - PARITY: par_chk_en=1. On bit_end, latch par_err into perr_q and go to STOP.
  - STOP: stp_chk_en=1. On bit_end, go to CHECK.
  - CHECK (one cycle):
    - data_valid registered: next cycle = !(perr_q | stp_err).
    - Then go to START if RX_IN==0 (back-to-back frame). In that case edge_count=1, presc_q re-latched, and bit_count is cleared. Otherwise go to IDLE.
- dat_samp_en=1 in every state except IDLE.
- All enables are Moore-decoded from the state register. data_valid is a register and is 0 in every cycle except the one after CHECK.
- PAR_EN is sampled at the end of the last data bit.
- perr_q is cleared on START entry. It stays 0 when PAR_EN=0.
- Reset asserted mid-frame: immediate return to IDLE, all outputs at reset values. No data_valid for the partial frame.
- Simultaneous RX_IN low and strt_glitch in START: strt_glitch wins at bit_end (abort). A new start is detected in IDLE on the following cycle.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, CHECK)
  - DATA_WIDTH, PRESC_W and EDGE_W localparams
  - legal prescale constants 8/16/32
- One sub-module, uart_rx_edge_bit_counter, holds the edge/bit counters, presc_q and bit_end generation. It is controlled by the FSM through enable and clear signals.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0x55 with a good stop bit -> START 8 cycles, DATA 64 cycles with deser_en=1, STOP 8 cycles. data_valid pulses exactly once, 81 cycles after start detect; bit_count runs 0..7.
- Prescale=16, PAR_EN=1, frame 0xA3 with par_err forced 1 during PARITY -> par_chk_en high for 16 cycles, data_valid stays 0, FSM returns to IDLE.
- Prescale=32, RX_IN low pulse of 4 cycles with strt_glitch=1 -> abort at edge_count=31, deser_en never asserted, state back in IDLE.
- Two back-to-back frames at Prescale=8 (0x0F then 0xF0), no idle gap -> CHECK goes directly to START. Two data_valid pulses occur; the second frame's edge_count starts at 1.
- Prescale switched 8->16 in mid-frame -> current frame still uses 8 (bit_end every 8 cycles). The next frame uses 16.
- rst pulled low during DATA at bit_count=4 -> all outputs 0 asynchronously. After release with RX_IN=1, the FSM stays in IDLE and no data_valid is seen.
